// File: rtl/ap_final_adder_8b.sv
// Final carry-propagate adder for an approximate multiplier: two-stage
// valid/ready pipeline with the carry chain cut at SPLIT. Optional macro AP_FINAL_SAT_EN.
module ap_final_adder_8b #(
  parameter int W     = 16,
  parameter int SPLIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] row_a,
  input  logic [W-1:0] row_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] prod,
  output logic         ovf
);

  localparam int HW = W - SPLIT;

  // Handshake: a transfer happens only in a cycle where valid && ready; a
  // producer holds valid/data until the transfer, ready never looks at valid.

  logic              s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0]  s1_lo_q, s1_lo_d;
  logic              s1_c1_q, s1_c1_d;
  logic [HW-1:0]     s1_ua_q, s1_ua_d;
  logic [HW-1:0]     s1_ub_q, s1_ub_d;

  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      prod_q, prod_d;
  logic              ovf_q, ovf_d;

  logic              s1_load;
  logic              s2_load;
  logic [SPLIT:0]    lo_sum;
  logic [HW:0]       hi_sum;

  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_load    = !s1_valid_q || s2_load;

    lo_sum     = {1'b0, row_a[SPLIT-1:0]} + {1'b0, row_b[SPLIT-1:0]};
    hi_sum     = {1'b0, s1_ua_q} + {1'b0, s1_ub_q} + {{HW{1'b0}}, s1_c1_q};

    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c1_d    = s1_c1_q;
    s1_ua_d    = s1_ua_q;
    s1_ub_d    = s1_ub_q;
    s2_valid_d = s2_valid_q;
    prod_d     = prod_q;
    ovf_d      = ovf_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_lo_d = lo_sum[SPLIT-1:0];
        s1_c1_d = lo_sum[SPLIT];
        s1_ua_d = row_a[W-1:SPLIT];
        s1_ub_d = row_b[W-1:SPLIT];
      end
    end

    // S2 data only moves when S2 is free to load, so a stalled result holds.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        ovf_d  = hi_sum[HW];
`ifdef AP_FINAL_SAT_EN
        prod_d = hi_sum[HW] ? {W{1'b1}} : {hi_sum[HW-1:0], s1_lo_q};
`else
        prod_d = {hi_sum[HW-1:0], s1_lo_q};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c1_q    <= 1'b0;
      s1_ua_q    <= '0;
      s1_ub_q    <= '0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c1_q    <= s1_c1_d;
      s1_ua_q    <= s1_ua_d;
      s1_ub_q    <= s1_ub_d;
      s2_valid_q <= s2_valid_d;
      prod_q     <= prod_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign prod      = prod_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ap_final_adder_8b.sv
// Directed and streaming bench for ap_final_adder_8b; expected sums are
// computed here, with the saturating variant selected by AP_FINAL_SAT_EN.
module tb_ap_final_adder_8b;

  localparam int W = 16;
  localparam int N_RAND = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] row_a = '0;
  logic [W-1:0] row_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] prod;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  ap_final_adder_8b #(.W(W), .SPLIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .row_a(row_a), .row_b(row_b), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Golden result packed as {ovf, prod}.
  function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef AP_FINAL_SAT_EN
    if (s[W]) s = {1'b1, {W{1'b1}}};
`endif
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, ovf, prod} !== {1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b ovf=%b prod=%h, want 0 0 0000", out_valid, ovf, prod);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Single pair through an empty pipeline with out_ready=1: valid 2 cycles later.
  task automatic apply_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W:0] exp, input string name);
    @(negedge clk);
    row_a = a; row_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid=%b after 1 cycle, want 0", name, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, prod} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL %s: out_valid=%b ovf=%b prod=%h, want 1 %b %h",
               name, out_valid, ovf, prod, exp[W], exp[W-1:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic test_basic();
    apply_pair(16'h1234, 16'h0F0F, {1'b0, 16'h2143}, "basic");
  endtask

  task automatic test_carry_split();
    apply_pair(16'h00FF, 16'h0001, {1'b0, 16'h0100}, "carry_split");
  endtask

  task automatic test_overflow();
`ifdef AP_FINAL_SAT_EN
    apply_pair(16'hFFFF, 16'h0002, {1'b1, 16'hFFFF}, "overflow");
`else
    apply_pair(16'hFFFF, 16'h0002, {1'b1, 16'h0001}, "overflow");
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sums [3];
    sums[0] = 16'h0003; sums[1] = 16'h0030; sums[2] = 16'h0300;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; row_a = 16'h0001; row_b = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    row_a = 16'h0010; row_b = 16'h0020;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    row_a = 16'h0100; row_b = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, prod} !== {1'b0, 1'b1, sums[0]}) begin
        errors++;
        $display("FAIL b2b_stall%0d: in_ready=%b out_valid=%b prod=%h, want 0 1 %h",
                 i, in_ready, out_valid, prod, sums[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if ({out_valid, prod} !== {1'b1, sums[i]}) begin
        errors++;
        $display("FAIL b2b_out%0d: out_valid=%b prod=%h, want 1 %h", i, out_valid, prod, sums[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_repeat: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; row_a = 16'h1111; row_b = 16'h2222;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, ovf, prod} !== {1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL mid_reset_async: out_valid=%b ovf=%b prod=%h, want 0 0 0000", out_valid, ovf, prod);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale%0d: out_valid=%b want 0", i, out_valid);
      end
    end
    apply_pair(16'h4000, 16'h0404, {1'b0, 16'h4404}, "after_reset");
  endtask

  task automatic test_stream();
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    logic hs_in, hs_out;
    logic [W:0] got, exp;
    exp_q.delete();
    while ((sent < N_RAND || exp_q.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      row_a     = W'($urandom);
      row_b     = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      got    = {ovf, prod};
      @(posedge clk);
      if (hs_in) begin
        exp_q.push_back(golden(row_a, row_b));
        sent++;
      end
      if (hs_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: unexpected output ovf=%b prod=%h", got[W], got[W-1:0]);
        end else begin
          exp = exp_q.pop_front();
          recv++;
          if (got !== exp) begin
            errors++;
            $display("FAIL stream_data%0d: ovf=%b prod=%h, want %b %h",
                     recv, got[W], got[W-1:0], exp[W], exp[W-1:0]);
          end
        end
      end
    end
    checks++;
    if (recv != N_RAND) begin
      errors++;
      $display("FAIL stream_count: received %0d want %0d (cycles=%0d)", recv, N_RAND, cycles);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_split();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
